word66_unloader: RTL and testbench

Drains a 66-bit result word, such as the product/remainder register of the multiply/divide unit, into a 32-bit datapath as a sequence of narrow beats. It captures the full word in one handshake, then presents it low slice first over a ready/valid output so the 32-bit writeback path can consume it at its own pace. It is the read-side counterpart of the 66-bit wide register: that register is loaded in one cycle, and this block unloads it over several.

---
 rtl/word66_unloader.sv | 120 ++++++++++++
 tb/tb_word66_unloader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/word66_unloader.sv
// word66_unloader: captures a WIDTH-bit result word in one handshake and
// drains it, low slice first, as BEAT-bit beats over a ready/valid output.
//
// Handshake semantics: a transfer happens on a rising edge when valid and
// ready are both high. Once out_valid is raised, out_data/out_idx/out_last
// stay stable until the beat is accepted. in_ready is combinational: it is
// high in IDLE, or in the last-beat cycle of SEND when out_ready is high.
// clr overrides every handshake in the cycle where it is asserted.
module word66_unloader #(
  parameter int WIDTH = 66,
  parameter int BEAT  = 32
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BEAT-1:0]  out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             dbg_state
);

  // Beat count is derived from the widths and intentionally not a parameter.
  localparam int NBEATS = (WIDTH + BEAT - 1) / BEAT;
  localparam int PADW   = NBEATS * BEAT;
  localparam logic [1:0] LAST_IDX = 2'(NBEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;

  logic [PADW-1:0]  w_padded;
  logic             w_send;
  logic             w_last;
  logic             w_xfer;
  logic             w_capture;

  // Held word zero-extended to a whole number of beats so the top slice
  // carries only the remaining high bits.
  assign w_padded  = PADW'(r_hold);
  assign w_send    = (r_state == ST_SEND);
  assign w_last    = w_send && (r_idx == LAST_IDX);
  assign w_xfer    = out_valid && out_ready;
  assign w_capture = in_valid && in_ready;

  // State register: clr discards any held word and returns to IDLE.
  always_ff @(posedge clock) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic: capture in IDLE, advance on beat transfer, and chain
  // straight into the next word when one is offered at the last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt = ST_SEND;
          w_hold_nxt  = in_data;
          w_idx_nxt   = '0;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (w_last) begin
            w_idx_nxt = '0;
            if (w_capture) begin
              w_hold_nxt  = in_data;
              w_state_nxt = ST_SEND;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: beat selection from the held word plus handshake flags.
  always_comb begin
    out_valid = w_send && !clr;
    in_ready  = !clr && (!w_send || (w_last && out_ready));
    out_data  = '0;
    if (w_send) begin
      out_data = w_padded[int'(r_idx) * BEAT +: BEAT];
    end
    out_idx   = r_idx;
    out_last  = w_last;
    busy      = w_send;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_word66_unloader.sv
// tb_word66_unloader: directed test-plan scenarios followed by randomized
// traffic, all compared against a queue-of-beats reference model.
module tb_word66_unloader;

  localparam int WIDTH  = 66;
  localparam int BEAT   = 32;
  localparam int NBEATS = 3;

  logic             clock;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BEAT-1:0]  out_data;
  logic [1:0]       out_idx;
  logic             out_last;
  logic             busy;
  logic             dbg_state;

  word66_unloader #(.WIDTH(WIDTH), .BEAT(BEAT)) dut (
    .clock     (clock),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Pending beats of the word in flight, front = beat currently presented.
  logic [BEAT-1:0] exp_q[$];
  logic [1:0]      exp_idx_q[$];

  int checks   = 0;
  int failures = 0;

  // Values observed in the most recent cycle, for directed spot checks.
  logic [BEAT-1:0] obs_data;
  logic [1:0]      obs_idx;
  logic            obs_valid;
  logic            obs_last;
  logic            obs_busy;
  logic            obs_in_ready;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Splits a word into its beats with plain shifts: beat k is bits
  // [32k +: 32] of the word, zero above bit 65.
  task automatic model_push(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] sh;
    for (int k = 0; k < NBEATS; k++) begin
      sh = w >> (BEAT * k);
      exp_q.push_back(sh[BEAT-1:0]);
      exp_idx_q.push_back(2'(k));
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, compare outputs mid-cycle, update the
  // model with what the coming edge should do.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic c);
    logic e_nonempty;
    logic e_in_ready;
    logic e_valid;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    @(negedge clock);
    e_nonempty = (exp_q.size() != 0);
    e_valid    = e_nonempty && !c;
    e_in_ready = !c && (!e_nonempty || (exp_q.size() == 1 && r));
    check_eq("out_valid", 64'(out_valid), 64'(e_valid));
    check_eq("in_ready",  64'(in_ready),  64'(e_in_ready));
    check_eq("busy",      64'(busy),      64'(e_nonempty));
    check_eq("dbg_state", 64'(dbg_state), 64'(e_nonempty));
    check_eq("out_data",  64'(out_data),  e_nonempty ? 64'(exp_q[0]) : 64'd0);
    check_eq("out_idx",   64'(out_idx),   e_nonempty ? 64'(exp_idx_q[0]) : 64'd0);
    check_eq("out_last",  64'(out_last),
             64'(e_nonempty && exp_idx_q[0] == 2'(NBEATS - 1)));
    obs_data     = out_data;
    obs_idx      = out_idx;
    obs_valid    = out_valid;
    obs_last     = out_last;
    obs_busy     = busy;
    obs_in_ready = in_ready;
    if (c) begin
      exp_q.delete();
      exp_idx_q.delete();
    end else begin
      if (e_valid && r) begin
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
      end
      if (v && e_in_ready) model_push(d);
    end
    @(posedge clock);
    #1;
  endtask

  localparam logic [WIDTH-1:0] WORD_A = 66'h2_DEADBEEF_12345678;
  localparam logic [WIDTH-1:0] WORD_B = 66'h1_CAFEF00D_0BADC0DE;

  logic [WIDTH-1:0] rnd_w;

  // ---------------- stimulus ----------------
  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr       = 1'b1;
    @(posedge clock);
    #1;
    cycle(1'b1, WORD_A, 1'b1, 1'b1);   // clr wins over an offered word
    cycle(1'b0, '0, 1'b0, 1'b0);       // reset state
    check_eq("rst_in_ready", 64'(obs_in_ready), 64'd1);
    check_eq("rst_busy",     64'(obs_busy),     64'd0);
    check_eq("rst_data",     64'(obs_data),     64'd0);

    // Basic drain
    cycle(1'b1, WORD_A, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("basic_b0", 64'(obs_data), 64'h12345678);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("basic_b1", 64'(obs_data), 64'hDEADBEEF);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("basic_b2", 64'(obs_data), 64'h2);
    check_eq("basic_last", 64'(obs_last), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("basic_idle", 64'(obs_busy), 64'd0);

    // Top-slice zero-extension
    cycle(1'b1, '1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("ones_b1", 64'(obs_data), 64'hFFFFFFFF);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("ones_b2", 64'(obs_data), 64'h3);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure on beat 1
    cycle(1'b1, WORD_A, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("bp_hold0", 64'(obs_data), 64'hDEADBEEF);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("bp_hold1", 64'(obs_idx), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("bp_hold2", 64'(obs_data), 64'hDEADBEEF);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("bp_b2", 64'(obs_data), 64'h2);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Busy lockout, chaining into a zero word
    cycle(1'b1, WORD_A, 1'b1, 1'b0);
    cycle(1'b1, '0, 1'b1, 1'b0);
    check_eq("lock_b0", 64'(obs_data), 64'h12345678);
    cycle(1'b1, '0, 1'b1, 1'b0);
    check_eq("lock_rdy1", 64'(obs_in_ready), 64'd0);
    cycle(1'b1, '0, 1'b1, 1'b0);
    check_eq("lock_rdy2", 64'(obs_in_ready), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("lock_zero_b0", 64'(obs_data), 64'h0);
    check_eq("lock_zero_v",  64'(obs_valid), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back A then B
    cycle(1'b1, WORD_A, 1'b1, 1'b0);
    cycle(1'b1, WORD_B, 1'b1, 1'b0);
    cycle(1'b1, WORD_B, 1'b1, 1'b0);
    cycle(1'b1, WORD_B, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("b2b_b0", 64'(obs_data), 64'h0BADC0DE);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("b2b_b2", 64'(obs_data), 64'h1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation during beat 1
    cycle(1'b1, WORD_A, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check_eq("rstmid_valid", 64'(obs_valid), 64'd0);
    check_eq("rstmid_rdy",   64'(obs_in_ready), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("rstmid_after_v", 64'(obs_valid), 64'd0);
    check_eq("rstmid_after_d", 64'(obs_data), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rnd_w = {$urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 2) != 0), rnd_w,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 49) == 0));
    end
    for (int n = 0; n < 8; n++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
